// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the ID-stage next-PC unit.
package pc_redirect_ctrl_pkg;

  // Default reset PC and exception vector.
  localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Redirect FSM encodings: IDLE = no held redirect, PENDING = target waiting on fetch.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Which source feeds the redirect target.
  typedef enum logic [1:0] {
    TGT_BR = 2'd0,
    TGT_J  = 2'd1,
    TGT_JR = 2'd2
  } tgt_sel_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_branch_target_calc.sv
// branch_target_calc: combinational redirect target select (jr > j > branch)
// and link address for the ID-stage instruction.
module branch_target_calc
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        j_i,
  input  logic        jr_i,
  input  logic [31:0] id_pc4_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] instr_idx_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] target_o,
  output logic [31:0] link_addr_o
);

  tgt_sel_e    sel;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  // Compute all candidate targets and pick one by priority.
  always_comb begin
    br_tgt      = id_pc4_i + {{14{imm_i[15]}}, imm_i, 2'b00};
    j_tgt       = {id_pc4_i[31:28], instr_idx_i, 2'b00};
    link_addr_o = id_pc4_i + 32'd4;
    if (jr_i)     sel = TGT_JR;
    else if (j_i) sel = TGT_J;
    else          sel = TGT_BR;
    case (sel)
      TGT_JR:  target_o = rs_val_i;
      TGT_J:   target_o = j_tgt;
      default: target_o = br_tgt;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: ID-stage next-PC unit owning the fetch PC register.
// Holds a redirect whose fetch has not been accepted yet; exceptions win over all.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        fetch_ready_i,
  input  logic        id_valid_i,
  input  logic        br_i,
  input  logic        br_taken_i,
  input  logic        j_i,
  input  logic        jr_i,
  input  logic        exc_i,
  input  logic [31:0] id_pc4_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] instr_idx_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] pc_o,
  output logic        pc_misalign_o,
  output logic [31:0] link_addr_o,
  output logic        redirect_pend_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] br_taken_cnt_o
);

  logic        id_fire;
  logic        redir;
  logic [31:0] target;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        misalign_q, misalign_d;

  branch_target_calc u_tgt (
    .j_i         (j_i),
    .jr_i        (jr_i),
    .id_pc4_i    (id_pc4_i),
    .imm_i       (imm_i),
    .instr_idx_i (instr_idx_i),
    .rs_val_i    (rs_val_i),
    .target_o    (target),
    .link_addr_o (link_addr_o)
  );

  assign id_fire = id_valid_i & ~stall_i;
  assign redir   = id_fire & ((br_i & br_taken_i) | j_i | jr_i);

  // Next-PC decision: exception, then pending release, then new redirect, then sequential.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_i) begin
      pc_d       = EXC_VECTOR;
      state_d    = ST_IDLE;
      pend_tgt_d = 32'd0;
    end else if (state_q == ST_PENDING) begin
      // The instruction behind a taken branch is its delay slot, so any
      // redirect seen while one is held cannot be legitimate and is ignored.
      if (fetch_ready_i) begin
        pc_d    = pend_tgt_q;
        state_d = ST_IDLE;
      end
    end else if (redir) begin
      if (fetch_ready_i) begin
        pc_d = target;
      end else begin
        pend_tgt_d = target;
        state_d    = ST_PENDING;
      end
    end else if (fetch_ready_i && !stall_i) begin
      pc_d = pc_q + 32'd4;
    end
    misalign_d = (pc_d[1:0] != 2'b00);
  end

  // PC, misalignment flag and redirect FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      state_q    <= ST_IDLE;
      pend_tgt_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_misalign_o   = misalign_q;
  assign redirect_pend_o = (state_q == ST_PENDING);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

  // Saturating counts of branches leaving ID and of those that were taken.
  always_comb begin
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;
    if (id_fire && br_i) begin
      br_cnt_d = sat_inc(br_cnt_q);
      if (br_taken_i) br_taken_cnt_d = sat_inc(br_taken_cnt_q);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q       <= 32'd0;
      br_taken_cnt_q <= 32'd0;
    end else begin
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign br_cnt_o       = br_cnt_q;
  assign br_taken_cnt_o = br_taken_cnt_q;
`else
  assign br_cnt_o       = 32'd0;
  assign br_taken_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with an expectation queue per clock edge.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_i, fetch_ready_i, id_valid_i, br_i, br_taken_i;
  logic        j_i, jr_i, exc_i;
  logic [31:0] id_pc4_i, rs_val_i;
  logic [15:0] imm_i;
  logic [25:0] instr_idx_i;
  logic [31:0] pc_o, link_addr_o, br_cnt_o, br_taken_cnt_o;
  logic        pc_misalign_o, redirect_pend_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        pend;
  } exp_t;
  exp_t exp_q[$];

  pc_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .fetch_ready_i   (fetch_ready_i),
    .id_valid_i      (id_valid_i),
    .br_i            (br_i),
    .br_taken_i      (br_taken_i),
    .j_i             (j_i),
    .jr_i            (jr_i),
    .exc_i           (exc_i),
    .id_pc4_i        (id_pc4_i),
    .imm_i           (imm_i),
    .instr_idx_i     (instr_idx_i),
    .rs_val_i        (rs_val_i),
    .pc_o            (pc_o),
    .pc_misalign_o   (pc_misalign_o),
    .link_addr_o     (link_addr_o),
    .redirect_pend_o (redirect_pend_o),
    .br_cnt_o        (br_cnt_o),
    .br_taken_cnt_o  (br_taken_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_in();
    stall_i = 0; id_valid_i = 0; br_i = 0; br_taken_i = 0;
    j_i = 0; jr_i = 0; exc_i = 0;
    id_pc4_i = 0; imm_i = 0; instr_idx_i = 0; rs_val_i = 0;
  endtask

  // Queue the expected post-edge state, advance one clock, then compare.
  task automatic step(input string tag, input logic [31:0] pc, input logic mis, input logic pend);
    exp_t e;
    e.pc = pc; e.mis = mis; e.pend = pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_pc"},   pc_o, e.pc);
    chk({tag, "_mis"},  {31'd0, pc_misalign_o}, {31'd0, e.mis});
    chk({tag, "_pend"}, {31'd0, redirect_pend_o}, {31'd0, e.pend});
  endtask

  task automatic branch(input logic [31:0] pc4, input logic [15:0] imm, input logic taken, input logic stall);
    idle_in();
    id_valid_i = 1; br_i = 1; br_taken_i = taken;
    id_pc4_i = pc4; imm_i = imm; stall_i = stall;
  endtask

  logic [31:0] exp_br, exp_tk;

  initial begin
    idle_in();
    fetch_ready_i = 1;
    rst = 1;
    @(posedge clk);
    step("reset", 32'hBFC0_0000, 1'b0, 1'b0);
    chk("reset_brcnt", br_cnt_o, 32'd0);
    chk("reset_tkcnt", br_taken_cnt_o, 32'd0);
    rst = 0;

    step("seq1", 32'hBFC0_0004, 1'b0, 1'b0);
    step("seq2", 32'hBFC0_0008, 1'b0, 1'b0);
    step("seq3", 32'hBFC0_000C, 1'b0, 1'b0);

    // Taken BEQ with negative offset.
    branch(32'h0000_0100, 16'hFFFE, 1'b1, 1'b0);
    #1;
    chk("beq_link", link_addr_o, 32'h0000_0104);
    step("beq", 32'h0000_00F8, 1'b0, 1'b0);

    // J while fetch not ready: held as pending, released on ready.
    idle_in();
    fetch_ready_i = 0;
    id_valid_i = 1; j_i = 1; id_pc4_i = 32'h8000_0010; instr_idx_i = 26'h0000040;
    step("j_hold1", 32'h0000_00F8, 1'b0, 1'b1);
    idle_in();
    step("j_hold2", 32'h0000_00F8, 1'b0, 1'b1);
    fetch_ready_i = 1;
    step("j_release", 32'h8000_0100, 1'b0, 1'b0);

    // Misaligned JR target.
    idle_in();
    id_valid_i = 1; jr_i = 1; rs_val_i = 32'h0000_0402;
    step("jr_mis", 32'h0000_0402, 1'b1, 1'b0);

    // Stalled taken branch is not consumed, then fires.
    branch(32'h0000_0200, 16'h0004, 1'b1, 1'b1);
    step("stall_br", 32'h0000_0402, 1'b1, 1'b0);
    branch(32'h0000_0200, 16'h0004, 1'b1, 1'b0);
    step("br_fwd", 32'h0000_0210, 1'b0, 1'b0);

    // Not-taken branch falls through.
    branch(32'h0000_0214, 16'h0040, 1'b0, 1'b0);
    step("br_nt", 32'h0000_0214, 1'b0, 1'b0);

    // Exception while a redirect is pending.
    idle_in();
    fetch_ready_i = 0;
    id_valid_i = 1; j_i = 1; id_pc4_i = 32'h0000_0300; instr_idx_i = 26'h0000100;
    step("exc_pend", 32'h0000_0214, 1'b0, 1'b1);
    idle_in();
    exc_i = 1;
    step("exc", EXC_VECTOR_DEF, 1'b0, 1'b0);
    idle_in();
    fetch_ready_i = 1;
    step("exc_after", 32'hBFC0_0384, 1'b0, 1'b0);

    // PC wrap at the top of the address space.
    idle_in();
    id_valid_i = 1; jr_i = 1; rs_val_i = 32'hFFFF_FFFC;
    step("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle_in();
    step("wrap", 32'h0000_0000, 1'b0, 1'b0);

    // Two more branches, the first with a stalled repeat.
    branch(32'h0000_0020, 16'h0001, 1'b1, 1'b1);
    step("stall_br2", 32'h0000_0000, 1'b0, 1'b0);
    branch(32'h0000_0020, 16'h0001, 1'b1, 1'b0);
    step("br_tk2", 32'h0000_0024, 1'b0, 1'b0);
    branch(32'h0000_0028, 16'h0100, 1'b0, 1'b0);
    step("br_nt2", 32'h0000_0028, 1'b0, 1'b0);
    idle_in();

`ifdef BRANCH_STATS_EN
    exp_br = 32'd5; exp_tk = 32'd3;
`else
    exp_br = 32'd0; exp_tk = 32'd0;
`endif
    chk("br_cnt", br_cnt_o, exp_br);
    chk("br_taken_cnt", br_taken_cnt_o, exp_tk);

    // Reset while a redirect is pending drops it.
    fetch_ready_i = 0;
    id_valid_i = 1; j_i = 1; id_pc4_i = 32'h0000_0400; instr_idx_i = 26'h0000200;
    step("rst_pend", 32'h0000_0028, 1'b0, 1'b1);
    idle_in();
    rst = 1;
    step("rst_mid", 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 0;
    fetch_ready_i = 1;
    step("rst_after", 32'hBFC0_0004, 1'b0, 1'b0);
    chk("rst_brcnt", br_cnt_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
